// File: rtl/reg_bank_par_if.sv
// Bus bundle for reg_bank_par: write port, two registered read ports, clear control and status.
interface reg_bank_par_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             regwen;
    logic [WIDTH-1:0] inA;
    logic [AW-1:0]    selwreg;
    logic [1:0]       endwreg;
    logic [AW-1:0]    seloutA;
    logic [AW-1:0]    seloutB;
    logic             cnstA;
    logic             cnstB;
    logic             enrregA;
    logic             enrregB;
    logic             clr;
    logic [WIDTH-1:0] outA;
    logic [WIDTH-1:0] outB;
    logic             busy;

    modport master (
        output regwen, inA, selwreg, endwreg, seloutA, seloutB,
               cnstA, cnstB, enrregA, enrregB, clr,
        input  outA, outB, busy
    );

    modport slave (
        input  regwen, inA, selwreg, endwreg, seloutA, seloutB,
               cnstA, cnstB, enrregA, enrregB, clr,
        output outA, outB, busy
    );
endinterface

// File: rtl/reg_bank_par.sv
// Complex-word register bank with lane-masked writes, two registered read ports and a clear sweep.
// Optional macro REG_BANK_BYPASS_EN forwards a same-edge write to a matching read port.
module reg_bank_par #(
    parameter int unsigned     WIDTH  = 64,
    parameter int unsigned     DEPTH  = 16,
    parameter logic [WIDTH-1:0] CNST_A = '0,
    parameter logic [WIDTH-1:0] CNST_B = '0
) (
    input logic          clock,
    input logic          reset,
    reg_bank_par_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned HW = WIDTH / 2;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;

    logic             wr_en;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Lane merge of the incoming word with the current contents of the target.
    always_comb begin
        wr_en  = bus.regwen && (state_q == IDLE);
        wr_old = mem_q[bus.selwreg];
        unique case (bus.endwreg)
            2'b00:   wr_merged = bus.inA;
            2'b01:   wr_merged = {wr_old[WIDTH-1:HW], bus.inA[HW-1:0]};
            2'b10:   wr_merged = {bus.inA[WIDTH-1:HW], wr_old[HW-1:0]};
            default: wr_merged = {bus.inA[HW-1:0], bus.inA[WIDTH-1:HW]};
        endcase
    end

    // Sweep FSM and bank next-state; the sweep owns the bank while it runs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        unique case (state_q)
            IDLE: begin
                if (wr_en) begin
                    mem_d[bus.selwreg] = wr_merged;
                end
                if (bus.clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[cnt_q] = '0;
                cnt_d        = AW'(cnt_q + 1'b1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CLEAR);
    end

    // Read ports: constant wins, then optional write forwarding, then stored contents.
    always_comb begin
        rd_a = mem_q[bus.seloutA];
        rd_b = mem_q[bus.seloutB];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en && (bus.selwreg == bus.seloutA)) rd_a = wr_merged;
        if (wr_en && (bus.selwreg == bus.seloutB)) rd_b = wr_merged;
`endif
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        if (bus.enrregA) out_a_d = bus.cnstA ? CNST_A : rd_a;
        if (bus.enrregB) out_b_d = bus.cnstB ? CNST_B : rd_b;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            mem_q   <= '{default: '0};
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            mem_q   <= mem_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
        end
    end

    assign bus.outA = out_a_q;
    assign bus.outB = out_b_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_reg_bank_par.sv
// Randomized and directed bench for reg_bank_par against a behavioural bank model.
module tb_reg_bank_par;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 16;
    localparam logic [63:0] CA = 64'h5;
    localparam logic [63:0] CB = 64'hC0DE_0000_0000_C0DE;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    reg_bank_par_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    reg_bank_par #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNST_A(CA), .CNST_B(CB)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Behavioural model: bank contents, expected outputs and remaining sweep cycles.
    logic [63:0] m_mem [DEPTH];
    logic [63:0] m_pre [DEPTH];
    logic [63:0] exp_a, exp_b, m_w;
    int          m_left;
    bit          m_acc;

    function automatic logic [63:0] lane(input logic [63:0] old, input logic [63:0] d,
                                         input logic [1:0] mode);
        case (mode)
            2'd0:    return d;
            2'd1:    return {old[63:32], d[31:0]};
            2'd2:    return {d[63:32], old[31:0]};
            default: return {d[31:0], d[63:32]};
        endcase
    endfunction

    function automatic logic [63:0] port_val(input bit acc, input int wa, input int ra,
                                             input logic [63:0] w, input logic [63:0] pre);
`ifdef REG_BANK_BYPASS_EN
        if (acc && wa == ra) return w;
`endif
        return pre;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            exp_a  = '0;
            exp_b  = '0;
            m_left = 0;
        end else begin
            m_pre = m_mem;
            m_acc = bus.regwen && (m_left == 0);
            m_w   = lane(m_pre[bus.selwreg], bus.inA, bus.endwreg);
            if (m_left > 0) begin
                m_mem[DEPTH - m_left] = '0;
                m_left--;
            end else begin
                if (m_acc) m_mem[bus.selwreg] = m_w;
                if (bus.clr) m_left = DEPTH;
            end
            if (bus.enrregA)
                exp_a = bus.cnstA ? CA : port_val(m_acc, int'(bus.selwreg), int'(bus.seloutA), m_w,
                                                  m_pre[bus.seloutA]);
            if (bus.enrregB)
                exp_b = bus.cnstB ? CB : port_val(m_acc, int'(bus.selwreg), int'(bus.seloutB), m_w,
                                                  m_pre[bus.seloutB]);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Every cycle out of reset the outputs must track the model.
    always @(negedge clock) begin
        if (!reset) begin
            check("outA", bus.outA, exp_a);
            check("outB", bus.outB, exp_b);
            check("busy", 64'(bus.busy), 64'(m_left > 0));
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic quiet();
        bus.regwen = 0; bus.clr = 0; bus.enrregA = 0; bus.enrregB = 0;
        bus.cnstA = 0; bus.cnstB = 0;
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic [1:0] m);
        bus.regwen = 1; bus.selwreg = 4'(a); bus.inA = d; bus.endwreg = m;
        tick();
        bus.regwen = 0;
    endtask

    task automatic rd(input int a, input int b);
        bus.enrregA = 1; bus.enrregB = 1; bus.seloutA = 4'(a); bus.seloutB = 4'(b);
        tick();
        bus.enrregA = 0; bus.enrregB = 0;
    endtask

    task automatic fill_nonzero();
        for (int i = 0; i < DEPTH; i++) wr(i, 64'h0100_0000_0000_0000 + 64'(i + 1), 2'd0);
    endtask

    initial begin
        int n;
        quiet();
        bus.inA = '0; bus.selwreg = '0; bus.endwreg = '0; bus.seloutA = '0; bus.seloutB = '0;
        #12 reset = 1'b0;
        tick();
        check("reset_outA", bus.outA, 64'h0);
        check("reset_busy", 64'(bus.busy), 64'h0);

        // Fill every register with {Re=20, Im=20}, read back on both ports.
        for (int i = 0; i < DEPTH; i++) wr(i, 64'h0000_0014_0000_0014, 2'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rd(i, DEPTH - 1 - i);
            check("fill_A", bus.outA, 64'h0000_0014_0000_0014);
            check("fill_B", bus.outB, 64'h0000_0014_0000_0014);
        end

        // Lane modes on reg[3].
        wr(3, 64'h1111_1111_2222_2222, 2'd0);
        wr(3, 64'hAAAA_AAAA_BBBB_BBBB, 2'd1);
        rd(3, 3);
        check("lane01", bus.outA, 64'h1111_1111_BBBB_BBBB);
        wr(3, 64'hAAAA_AAAA_BBBB_BBBB, 2'd2);
        rd(3, 3);
        check("lane10", bus.outA, 64'hAAAA_AAAA_BBBB_BBBB);
        wr(3, 64'hAAAA_AAAA_BBBB_BBBB, 2'd3);
        rd(3, 3);
        check("lane11", bus.outB, 64'hBBBB_BBBB_AAAA_AAAA);

        // Constant on A; B holds with its enable low.
        bus.cnstA = 1; bus.enrregA = 1; bus.seloutA = 4'd3;
        tick();
        check("cnstA", bus.outA, 64'h5);
        quiet();
        for (int i = 0; i < 4; i++) begin
            bus.seloutB = 4'(i * 5);
            tick();
            check("holdB", bus.outB, 64'hBBBB_BBBB_AAAA_AAAA);
        end

        // Clear sweep with a dropped write at busy cycle 5.
        fill_nonzero();
        bus.clr = 1;
        tick();
        bus.clr = 0;
        n = 0;
        while (bus.busy && n < 40) begin
            if (n == 4) begin
                bus.regwen = 1; bus.selwreg = 4'd2; bus.inA = 64'hDEAD_BEEF_DEAD_BEEF; bus.endwreg = 0;
            end else bus.regwen = 0;
            tick();
            n++;
        end
        bus.regwen = 0;
        check("busy_len", 64'(n), 64'd16);
        for (int i = 0; i < DEPTH; i++) begin
            rd(i, i);
            check("cleared", bus.outA, 64'h0);
        end

        // Same-edge write/read on address 7.
        wr(7, 64'h99, 2'd0);
        bus.regwen = 1; bus.selwreg = 4'd7; bus.inA = 64'h1234; bus.endwreg = 0;
        bus.enrregA = 1; bus.seloutA = 4'd7;
        tick();
        quiet();
`ifdef REG_BANK_BYPASS_EN
        check("bypass", bus.outA, 64'h1234);
`else
        check("bypass", bus.outA, 64'h99);
`endif

        // Reset at sweep cycle 8, observed without any clock edge.
        fill_nonzero();
        bus.clr = 1;
        tick();
        bus.clr = 0; bus.enrregA = 1; bus.enrregB = 1; bus.seloutA = 4'd15; bus.seloutB = 4'd14;
        for (int i = 0; i < 7; i++) tick();
        check("pre_reset_A", bus.outA, 64'h0100_0000_0000_0010);
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_outA", bus.outA, 64'h0);
        check("rst_outB", bus.outB, 64'h0);
        quiet();
        tick();
        #1 reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd(i, i);
            check("rst_mem", bus.outB, 64'h0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            bus.regwen  = 1'($urandom_range(0, 1));
            bus.inA     = {$urandom, $urandom};
            bus.selwreg = 4'($urandom);
            bus.endwreg = 2'($urandom);
            bus.seloutA = 4'($urandom);
            bus.seloutB = ($urandom_range(0, 3) == 0) ? bus.seloutA : 4'($urandom);
            bus.cnstA   = ($urandom_range(0, 7) == 0);
            bus.cnstB   = ($urandom_range(0, 7) == 0);
            bus.enrregA = ($urandom_range(0, 3) != 0);
            bus.enrregB = ($urandom_range(0, 3) != 0);
            bus.clr     = ($urandom_range(0, 49) == 0);
            tick();
        end
        quiet();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
